spram_ctrl: RTL and testbench

Request/response controller sitting directly upstream of the single-port RAM (`single_port_ram`): accepts one read or write request at a time over a valid/ready handshake and sequences the RAM's `cs`/`we`/`oe`/`addr` pins and shared bidirectional `data` bus. It returns the read data or write acknowledge on a response channel. It replaces direct pin-wiggling of the RAM by client logic.

---
 rtl/spram_ctrl_pkg.sv | 26 ++
 rtl/spram_bus_io.sv | 15 +
 rtl/spram_ctrl.sv | 168 ++++++++++++++++
 tb/tb_spram_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_ctrl_pkg.sv
// Shared types for the single-port RAM request/response controller.
// The TURN state is only entered when SPRAM_CTRL_TURNAROUND_EN is defined.
package spram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_RESP  = 3'd4,
    ST_TURN  = 3'd5
  } state_e;

  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

  // States in which the RAM is selected.
  function automatic logic is_access(input state_e s);
    return (s == ST_WRITE) || (s == ST_READ) || (s == ST_CAPT);
  endfunction

  function automatic logic is_read_phase(input state_e s);
    return (s == ST_READ) || (s == ST_CAPT);
  endfunction

endpackage

// File: rtl/spram_bus_io.sv
// Tri-state driver for the shared RAM data bus; keeps all inout logic in
// one place so the rest of the controller is purely unidirectional.
module spram_bus_io #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 drive_en_i,
  input  logic [DATAWIDTH-1:0] wdata_i,
  output logic [DATAWIDTH-1:0] rdata_o,
  inout  wire  [DATAWIDTH-1:0] bus_io
);

  assign bus_io  = drive_en_i ? wdata_i : {DATAWIDTH{1'bz}};
  assign rdata_o = bus_io;

endmodule

// File: rtl/spram_ctrl.sv
// Valid/ready request/response front end for a single-port RAM.
// Define SPRAM_CTRL_TURNAROUND_EN to insert a dead TURN cycle after reads.
module spram_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 8,
  parameter int SIZE      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic [DATAWIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 ram_cs,
  output logic                 ram_we,
  output logic                 ram_oe,
  output logic [ADDRWIDTH-1:0] ram_addr,
  inout  wire  [DATAWIDTH-1:0] ram_data
);

  // One extra bit so SIZE == 2**ADDRWIDTH is representable.
  localparam logic [ADDRWIDTH:0] SIZE_L = (ADDRWIDTH+1)'(SIZE);

  state_e                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   addr_q, addr_d;
  logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
  logic [DATAWIDTH-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;
`ifdef SPRAM_CTRL_TURNAROUND_EN
  logic                   we_q, we_d;
`endif

  logic                   req_ready_q, req_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   cs_q, cs_d;
  logic                   rwe_q, rwe_d;
  logic                   oe_q, oe_d;
  logic                   drive_q, drive_d;

  logic                   addr_err_s;
  logic [DATAWIDTH-1:0]   bus_rdata_s;

  assign addr_err_s = ({1'b0, req_addr} >= SIZE_L);

  spram_bus_io #(
    .DATAWIDTH (DATAWIDTH)
  ) u_bus_io (
    .drive_en_i (drive_q),
    .wdata_i    (wdata_q),
    .rdata_o    (bus_rdata_s),
    .bus_io     (ram_data)
  );

  // Next-state and request/response datapath.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef SPRAM_CTRL_TURNAROUND_EN
    we_d    = we_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = {DATAWIDTH{1'b0}};
`ifdef SPRAM_CTRL_TURNAROUND_EN
          we_d    = req_we;
`endif
          if (addr_err_s) begin
            err_d   = RSP_ERR;
            state_d = ST_RESP;
          end else begin
            err_d   = RSP_OK;
            state_d = req_we ? ST_WRITE : ST_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_READ:  state_d = ST_CAPT;
      ST_CAPT: begin
        rdata_d = bus_rdata_s;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
`ifdef SPRAM_CTRL_TURNAROUND_EN
          // Only a real read left the RAM driving the bus.
          state_d = (!we_q && (err_q == RSP_OK)) ? ST_TURN : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_TURN:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  // while still lining up with the state they belong to.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    cs_d        = is_access(state_d);
    rwe_d       = (state_d == ST_WRITE);
    oe_d        = is_read_phase(state_d);
    drive_d     = (state_d == ST_WRITE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= {ADDRWIDTH{1'b0}};
      wdata_q     <= {DATAWIDTH{1'b0}};
      rdata_q     <= {DATAWIDTH{1'b0}};
      err_q       <= 1'b0;
`ifdef SPRAM_CTRL_TURNAROUND_EN
      we_q        <= 1'b0;
`endif
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      cs_q        <= 1'b0;
      rwe_q       <= 1'b0;
      oe_q        <= 1'b0;
      drive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
`ifdef SPRAM_CTRL_TURNAROUND_EN
      we_q        <= we_d;
`endif
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      cs_q        <= cs_d;
      rwe_q       <= rwe_d;
      oe_q        <= oe_d;
      drive_q     <= drive_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign ram_cs    = cs_q;
  assign ram_we    = rwe_q;
  assign ram_oe    = oe_q;
  assign ram_addr  = addr_q;

endmodule

// File: tb/tb_spram_ctrl.sv
// Self-checking bench for spram_ctrl: RAM model on the bus plus a
// transaction-level latency model checked every cycle on the falling edge.
module tb_spram_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int SZ = 12;
`ifdef SPRAM_CTRL_TURNAROUND_EN
  localparam int RD_GAP = 5;
`else
  localparam int RD_GAP = 4;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic          rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_err, ram_cs, ram_we, ram_oe;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;

  always #5 clk = ~clk;

  spram_ctrl #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .SIZE(SZ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data)
  );

  // RAM: writes on the edge, samples the read address at the end of the
  // first read cycle and drives the bus in the following one.
  logic [DW-1:0] ram_mem [0:15];
  logic [DW-1:0] rd_q;
  logic          rd_ok;
  always @(posedge clk) begin
    if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_data;
    rd_ok <= ram_cs && ram_oe && !ram_we;
    rd_q  <= ram_mem[ram_addr];
  end
  assign ram_data = (ram_cs && ram_oe && !ram_we && rd_ok) ? rd_q : {DW{1'bz}};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: kind 0 = write, 1 = read, 2 = address error.
  logic [DW-1:0] mem_m [0:15];
  bit            busy = 1'b0;
  bit            turn = 1'b0;
  int            k = 0;
  int            kind = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  int            cyc = 0;
  int            last_acc = 0;
  int            last_kind = 0;
  bit            last_cad = 1'b0;
  bit            cad_on = 1'b0;
  bit            e_valid, e_cs, e_we, e_oe;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      e_valid = busy && ((kind == 2 && k >= 1) || (kind == 0 && k >= 2) || (kind == 1 && k >= 3));
      e_we    = busy && kind == 0 && k == 1;
      e_oe    = busy && kind == 1 && (k == 1 || k == 2);
      e_cs    = e_we || e_oe;
      chk("req_ready", req_ready, !busy && !turn);
      chk("rsp_valid", rsp_valid, e_valid);
      chk("ram_cs", ram_cs, e_cs);
      chk("ram_we", ram_we, e_we);
      chk("ram_oe", ram_oe, e_oe);
      if (e_cs) chk("ram_addr", ram_addr, m_addr);
      if (e_we) chk("ram_wdata", ram_data, m_wdata);
      if (e_valid) begin
        chk("rsp_err", rsp_err, kind == 2);
        chk("rsp_rdata", rsp_rdata, (kind == 1) ? m_rdata : 8'h00);
      end
      // Predict the effect of the coming rising edge.
      if (!rst_n) begin
        busy = 1'b0;
        turn = 1'b0;
      end else if (turn) begin
        turn = 1'b0;
      end else if (!busy) begin
        if (req_valid) begin
          if (cad_on && last_cad) chk("cadence", cyc - last_acc, (last_kind == 0) ? 3 : RD_GAP);
          last_acc  = cyc;
          last_cad  = cad_on && (req_addr < SZ);
          last_kind = req_we ? 0 : 1;
          busy      = 1'b1;
          k         = 1;
          m_addr    = req_addr;
          m_wdata   = req_wdata;
          kind      = (req_addr >= SZ) ? 2 : (req_we ? 0 : 1);
          m_rdata   = mem_m[req_addr];
        end
      end else if (e_valid && rsp_ready) begin
        busy = 1'b0;
`ifdef SPRAM_CTRL_TURNAROUND_EN
        turn = (kind == 1);
`endif
      end else begin
        if (kind == 0 && k == 1) mem_m[m_addr] = m_wdata;
        k++;
      end
    end
  end

  int rr_mode = 0;  // 0: always ready, 1: random, 2: held low
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 9) < 7);
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int guard = 0;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && guard < 64) begin
      guard++;
      @(negedge clk);
    end
    if (!req_ready) chk("accept_timeout", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || turn) && guard < 100) begin
      guard++;
      @(posedge clk);
      #1;
    end
    if (busy || turn) chk("idle_timeout", busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Request held during reset must be ignored.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd2; req_wdata = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_ram_cs", ram_cs, 1'b0);
    chk("rst_ram_addr", ram_addr, 4'd0);
    rst_n = 1'b1;
    req_valid = 1'b0;
    rr_mode = 0;
    @(posedge clk);
    #1;

    // Directed write 0xA5 to address 3.
    send(1'b1, 4'd3, 8'hA5);
    @(negedge clk);
    chk("wr_cs", ram_cs, 1'b1);
    chk("wr_we", ram_we, 1'b1);
    chk("wr_oe", ram_oe, 1'b0);
    chk("wr_addr", ram_addr, 4'd3);
    chk("wr_data", ram_data, 8'hA5);
    chk("wr_early_valid", rsp_valid, 1'b0);
    @(negedge clk);
    chk("wr_rsp_valid", rsp_valid, 1'b1);
    chk("wr_rsp_err", rsp_err, 1'b0);
    chk("wr_rsp_rdata", rsp_rdata, 8'h00);
    chk("wr_resp_cs", ram_cs, 1'b0);
    wait_idle();

    // Directed read back of address 3.
    send(1'b0, 4'd3, 8'h00);
    @(negedge clk);
    chk("rd_cs", ram_cs, 1'b1);
    chk("rd_oe", ram_oe, 1'b1);
    chk("rd_we", ram_we, 1'b0);
    @(negedge clk);
    chk("capt_valid", rsp_valid, 1'b0);
    chk("capt_bus", ram_data, 8'hA5);
    @(negedge clk);
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_rsp_rdata", rsp_rdata, 8'hA5);
    wait_idle();

    // Out-of-range address.
    send(1'b0, 4'd13, 8'h00);
    @(negedge clk);
    chk("err_valid", rsp_valid, 1'b1);
    chk("err_flag", rsp_err, 1'b1);
    chk("err_cs", ram_cs, 1'b0);
    wait_idle();

    // Fill every address back-to-back, then read them back in order.
    cad_on = 1'b1;
    for (int a = 0; a < 16; a++) send(1'b1, AW'(a), DW'($urandom));
    for (int a = 0; a < 16; a++) send(1'b0, AW'(a), 8'h00);
    cad_on = 1'b0;
    wait_idle();

    // Stalled read response, with a write queued behind it.
    rr_mode = 2;
    send(1'b0, 4'd5, 8'h00);
    fork
      begin
        repeat (7) @(posedge clk);
        rr_mode = 0;
      end
      send(1'b1, 4'd6, 8'h3C);
    join
    wait_idle();

    // Reset during the capture cycle drops the read.
    send(1'b0, 4'd4, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("capt_rst_ready", req_ready, 1'b1);
    chk("capt_rst_valid", rsp_valid, 1'b0);
    chk("capt_rst_cs", ram_cs, 1'b0);
    chk("capt_rst_oe", ram_oe, 1'b0);
    chk("capt_rst_addr", ram_addr, 4'd0);
    chk("capt_rst_rdata", rsp_rdata, 8'h00);
    repeat (4) @(posedge clk);
    #1;

    // Random traffic with random back-pressure.
    rr_mode = 1;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
    end
    rr_mode = 0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
